muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit on the consumer side of the operand path.
- Takes operand A and the selected operand B (rdata2 or immediate) plus a funct3 op code.
- Produces a 32-bit result after a fixed multi-cycle latency, using a start/busy/done handshake.
- Sits beside the single-cycle ALU; the control unit stalls the PC while busy is high.

Parameters:
- XLEN, 32, operand and result width.
- ITER, 32, iteration cycles in CALC; equals XLEN, one bit per cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- kill  input  1  abort of an in-flight operation (pipeline flush).
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opr_a  input  XLEN  operand A, rs1.
- opr_b  input  XLEN  operand B, output of the operand-B mux.
- busy  output  1  high in CALC, FIX and DONE.
- done  output  1  one-cycle pulse; result valid in this cycle.
- result  output  XLEN  result; holds its value until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset takes effect immediately, including mid-operation; no done is produced for the aborted operation.
- States:
  - IDLE: start=1 at a rising edge latches op, opr_a, opr_b → CALC. The iteration counter is loaded to 0.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per edge, on absolute values for signed variants. After the ITER-th step → FIX.
  - FIX: apply sign correction and select the result; latch it into result → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Latency: the accept edge counts as edge 0; done is high in the cycle after edge ITER+2, i.e. 34 cycles for XLEN=32. Latency is fixed for every op and operand value; there is no early exit.
- busy is registered and goes high in the cycle after the accept edge. start while busy is ignored, not queued.
- kill=1 at an edge in CALC or FIX → IDLE, no done, result unchanged. kill in DONE has no effect (done still pulses). kill in IDLE blocks a simultaneous start. kill has priority over start.
- Multiply: 64-bit product from unsigned magnitudes.
  - MULH: signed×signed. MULHSU: opr_a signed, opr_b unsigned. MULHU: unsigned×unsigned.
  - Negate the 64-bit product when the sign flag is set.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Signed only for DIV and REM.
- Divide by zero (opr_b=0): quotient = 0xFFFF_FFFF for DIV and DIVU; remainder = opr_a for REM and REMU.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM of the same operands → 0.
- Special cases still take full latency. Operands are latched at accept; input changes during busy have no effect.
- done and busy never both low while the state is not IDLE. done is never asserted except in DONE.

Test Plan:
- Reset, then MUL a=7 b=-3 (0xFFFF_FFFD): busy high from the cycle after accept; done in cycle 34 with result=0xFFFF_FFEB; done low the next cycle with result held.
- MULHU a=0xFFFF_FFFF b=0xFFFF_FFFF → 0xFFFF_FFFE. MULH same operands → 0x0000_0000. MULHSU a=-1 b=2 → 0xFFFF_FFFF.
- DIV a=-7 b=2 → 0xFFFF_FFFD; REM → 0xFFFF_FFFF; DIVU a=100 b=7 → 14; REMU → 2.
- Divide by zero: DIV a=5 b=0 → 0xFFFF_FFFF; REM → 5. Overflow: DIV 0x8000_0000/-1 → 0x8000_0000, REM → 0. All at the 34-cycle latency.
- start pulsed again in cycle 10 of a busy op with different operands → ignored; first result unchanged; next start after done accepted normally.
- kill in cycle 15 → idle next cycle, no done, result keeps its prior value. Separately, rst_n low in cycle 20 → busy=0 and result=0 immediately, no done.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Operands are magnitude-converted once, then processed one bit per clock:
// shift-add for multiply, restoring subtract for divide. A final fix-up
// cycle applies sign correction and the divide special cases. Latency is
// fixed for every op and operand value.
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - operation request, sampled only while idle
//   kill    - abort an in-flight operation; wins over start
//   op      - funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   opr_a   - operand A (rs1)
//   opr_b   - operand B (rs2 or immediate)
//   busy    - high while an operation occupies the unit
//   done    - one-cycle pulse, result valid in this cycle
//   result  - last completed result, held until the next completion
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]       op_q;
    logic [XLEN-1:0]  a_raw;
    logic [XLEN-1:0]  b_raw;
    logic [XLEN-1:0]  hi;    // multiply: product high half; divide: partial remainder
    logic [XLEN-1:0]  lo;    // multiply: multiplier/product low half; divide: quotient
    logic [CNT_W-1:0] cnt;

    // Two's complement negate when flag is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic            can_sub;
    logic [XLEN-1:0] rem_diff;
    logic [2*XLEN-1:0] product_fix;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_value;

    assign is_div   = op_q[2];
    assign a_signed = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    assign b_signed = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    assign a_neg    = a_signed && a_raw[XLEN-1];
    assign b_neg    = b_signed && b_raw[XLEN-1];
    assign b_zero   = (b_raw == '0);
    assign b_mag    = cond_neg(b_neg, b_raw);

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift {carry, hi, lo} right by one.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);

    // Restoring-divide step. The remainder stays below b_mag, so the
    // difference fits in XLEN bits whenever the subtraction is taken.
    assign rem_shift = {hi, lo[XLEN-1]};
    assign can_sub   = (rem_shift >= {1'b0, b_mag});
    assign rem_diff  = rem_shift[XLEN-1:0] - b_mag;

    // MUL's low half is sign-agnostic, so it shares the unsigned path.
    assign product_fix = cond_neg_wide(a_neg ^ b_neg, {hi, lo});
    assign quot_fix    = cond_neg(a_neg ^ b_neg, lo);
    assign rem_fix     = cond_neg(a_neg, hi);

    always_comb begin
        fix_value = '0;
        case (op_q)
            3'd0:                fix_value = product_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_value = product_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_value = b_zero ? '1 : quot_fix;
            default:             fix_value = b_zero ? a_raw : rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start && !kill) state_next = S_CALC;
            S_CALC: begin
                if (kill)
                    state_next = S_IDLE;
                else if (cnt == CNT_W'(ITER))
                    state_next = S_FIX;
            end
            S_FIX:  state_next = kill ? S_IDLE : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_raw  <= '0;
            b_raw  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_q  <= op;
                        a_raw <= opr_a;
                        b_raw <= opr_b;
                        cnt   <= '0;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == '0) begin
                        // First CALC edge loads |a| as the working operand.
                        hi <= '0;
                        lo <= cond_neg(a_neg, a_raw);
                    end else if (is_div) begin
                        hi <= can_sub ? rem_diff : rem_shift[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], can_sub};
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    if (!kill) result <= fix_value;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'h0;

    localparam int LAT = 34;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .opr_a  (opr_a),
        .opr_b  (opr_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Reference model built on native 64-bit and signed 32-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] sa32, sb32;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa32 = a;
        sb32 = b;
        r = 32'h0;
        p = 64'sh0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = sa32 / sb32;
            end
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = sa32 % sb32;
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic accept(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        @(negedge clk);
        op = f;
        opr_a = a;
        opr_b = b;
        start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        start = 1'b0;
        opr_a = $urandom;
        opr_b = $urandom;
        op = 3'($urandom);
    endtask

    // offset = index of the edge most recently passed since the accept edge.
    task automatic wait_done(input string name, input int offset);
        int k;
        bit seen;
        logic [31:0] expv;
        seen = 0;
        k = offset;
        while (!seen && k < offset + 100) begin
            @(negedge clk);
            if (k == 0) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
                end
            end
            if (done === 1'b1) seen = 1;
            else k++;
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s timeout: no done within bound, want done at edge %0d", name, LAT);
        end else begin
            vectors++;
            if (k !== LAT) begin
                miscompares++;
                $display("FAIL %s latency: got %0d want %0d", name, k, LAT);
            end
            if (result !== expv) begin
                miscompares++;
                $display("FAIL %s result: got %h want %h", name, result, expv);
            end
        end
        last_res = expv;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== expv) begin
            miscompares++;
            $display("FAIL %s after_done: got done=%b busy=%b result=%h want done=0 busy=0 result=%h",
                     name, done, busy, result, expv);
        end
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        bit bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s spurious_activity: got done/busy high, want idle", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        kill = 1'b0;
        op = 3'd0;
        opr_a = 32'h0;
        opr_b = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        rst_n = 1'b1;
        last_res = 32'h0;
    endtask

    task automatic test_mul();
        accept(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        wait_done("mul_7_m3", 0);
        accept(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done("mulhu_max", 0);
        accept(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_done("mulh_m1_m1", 0);
        accept(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        wait_done("mulhsu_m1_2", 0);
    endtask

    task automatic test_div();
        accept(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        wait_done("div_m7_2", 0);
        accept(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        wait_done("rem_m7_2", 0);
        accept(3'd5, 32'd100, 32'd7, 32'd14);
        wait_done("divu_100_7", 0);
        accept(3'd7, 32'd100, 32'd7, 32'd2);
        wait_done("remu_100_7", 0);
    endtask

    task automatic test_div_special();
        accept(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        wait_done("div_by_zero", 0);
        accept(3'd6, 32'd5, 32'd0, 32'd5);
        wait_done("rem_by_zero", 0);
        accept(3'd5, 32'hF000_0005, 32'd0, 32'hFFFF_FFFF);
        wait_done("divu_by_zero", 0);
        accept(3'd7, 32'hF000_0005, 32'd0, 32'hF000_0005);
        wait_done("remu_by_zero", 0);
        accept(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("div_overflow", 0);
        accept(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        wait_done("rem_overflow", 0);
    endtask

    task automatic test_start_while_busy();
        accept(3'd5, 32'd1000, 32'd3, 32'd333);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        opr_a = 32'd9;
        opr_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_ignored", 10);
        accept(3'd0, 32'd9, 32'd9, 32'd81);
        wait_done("start_after_done", 0);
    endtask

    task automatic test_kill();
        accept(3'd1, 32'h1234_5678, 32'h8765_4321, 32'h0);
        void'(exp_q.pop_back());
        repeat (14) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
            miscompares++;
            $display("FAIL kill_mid_calc: got busy=%b done=%b result=%h want 0 0 %h",
                     busy, done, result, last_res);
        end
        watch_no_done("kill_no_done", 40);
        // kill alongside start in IDLE blocks the accept
        @(negedge clk);
        start = 1'b1;
        kill = 1'b1;
        op = 3'd0;
        opr_a = 32'd2;
        opr_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill = 1'b0;
        watch_no_done("kill_blocks_start", 40);
        vectors++;
        if (result !== last_res) begin
            miscompares++;
            $display("FAIL kill_result_held: got %h want %h", result, last_res);
        end
    endtask

    task automatic test_reset_mid();
        accept(3'd4, 32'd77, 32'd5, 32'd15);
        void'(exp_q.pop_back());
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_op: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        last_res = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("reset_no_done", 40);
    endtask

    task automatic test_back_to_back();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            f = 3'(i % 8);
            a = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            accept(f, a, b, model(f, a, b));
            wait_done($sformatf("rand_%0d_op%0d", i, f), 0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_start_while_busy();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
